esc_phase_timer: RTL and testbench

Escalation phase sequencer that drives the escalation-enable requests consumed by the NMI generator's escalation receivers. On an accumulator trigger or an expired interrupt timeout it steps through four programmable-duration phases and asserts each of `N_ESC_SEV` escalation signals from a programmed phase onward. It sits between the per-class alert accumulator/configuration registers and the escalation senders feeding `nmi_gen`.

---
 rtl/esc_phase_timer_if.sv | 30 +++
 rtl/esc_phase_timer.sv | 116 +++++++++++
 tb/tb_esc_phase_timer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/esc_phase_timer_if.sv
// Trigger/config/escalation bundle between the class registers and esc_phase_timer.
// slave: the sequencer side; master: the register/accumulator side.
interface esc_phase_timer_if #(
  parameter int N_ESC_SEV = 4,
  parameter int CntDw     = 16
);
  logic                   en_i;
  logic                   clr_i;
  logic                   accum_trig_i;
  logic                   timeout_en_i;
  logic [CntDw-1:0]       timeout_cyc_i;
  logic [4*CntDw-1:0]     phase_cyc_i;
  logic [2*N_ESC_SEV-1:0] esc_map_i;
  logic [N_ESC_SEV-1:0]   esc_sig_en_i;
  logic [N_ESC_SEV-1:0]   esc_en_o;
  logic [CntDw-1:0]       esc_cnt_o;
  logic [2:0]             esc_state_o;

  modport slave (
    input  en_i, clr_i, accum_trig_i, timeout_en_i,
           timeout_cyc_i, phase_cyc_i, esc_map_i, esc_sig_en_i,
    output esc_en_o, esc_cnt_o, esc_state_o
  );

  modport master (
    output en_i, clr_i, accum_trig_i, timeout_en_i,
           timeout_cyc_i, phase_cyc_i, esc_map_i, esc_sig_en_i,
    input  esc_en_o, esc_cnt_o, esc_state_o
  );
endinterface

// File: rtl/esc_phase_timer.sv
// Escalation phase sequencer: timeout counter plus four programmable phases.
// Define ESC_PHASE_TIMER_CLR_LOCK_EN to make clr_i ineffective once a phase sequence has begun.
module esc_phase_timer #(
  parameter int N_ESC_SEV = 4,
  parameter int CntDw     = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  esc_phase_timer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    TIMEOUT  = 3'b001,
    TERMINAL = 3'b011,
    PHASE0   = 3'b100,
    PHASE1   = 3'b101,
    PHASE2   = 3'b110,
    PHASE3   = 3'b111
  } state_e;

  state_e           state_q, state_d;
  logic [CntDw-1:0] cnt_q, cnt_d;
  logic [CntDw-1:0] phase_cyc;
  logic [CntDw-1:0] phase_lim;
  logic [CntDw-1:0] tmo_lim;
  logic             clr_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A zero phase length is treated as one cycle, so the limit is max(D,1)-1.
  always_comb begin
    phase_cyc = bus.phase_cyc_i[state_q[1:0]*CntDw +: CntDw];
    phase_lim = (phase_cyc == '0) ? '0 : phase_cyc - CntDw'(1);
    tmo_lim   = bus.timeout_cyc_i - CntDw'(1);
`ifdef ESC_PHASE_TIMER_CLR_LOCK_EN
    clr_ok    = bus.clr_i & ~state_q[2];
`else
    clr_ok    = bus.clr_i;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.en_i && bus.accum_trig_i) begin
          state_d = PHASE0;
        end else if (bus.en_i && bus.timeout_en_i && bus.timeout_cyc_i != '0) begin
          state_d = TIMEOUT;
        end
      end
      TIMEOUT: begin
        if (bus.accum_trig_i) begin
          state_d = PHASE0;
          cnt_d   = '0;
        end else if (!bus.timeout_en_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= tmo_lim) begin
          state_d = PHASE0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntDw'(1);
        end
      end
      PHASE0, PHASE1, PHASE2, PHASE3: begin
        if (cnt_q >= phase_lim) begin
          cnt_d = '0;
          unique case (state_q)
            PHASE0:  state_d = PHASE1;
            PHASE1:  state_d = PHASE2;
            PHASE2:  state_d = PHASE3;
            default: state_d = TERMINAL;
          endcase
        end else begin
          cnt_d = cnt_q + CntDw'(1);
        end
      end
      TERMINAL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (clr_ok) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Outputs decode from the state flop only; bit 2 marks the phase states.
  always_comb begin
    for (int k = 0; k < N_ESC_SEV; k++) begin
      bus.esc_en_o[k] = bus.esc_sig_en_i[k] & state_q[2] &
                        (state_q[1:0] >= bus.esc_map_i[2*k +: 2]);
    end
  end

  assign bus.esc_cnt_o   = cnt_q;
  assign bus.esc_state_o = state_q;

endmodule

// File: tb/tb_esc_phase_timer.sv
// Bench for esc_phase_timer: vector table, directed corner sequences and a randomized model run.
module tb_esc_phase_timer;
  localparam int N = 4;
  localparam int W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  esc_phase_timer_if #(.N_ESC_SEV(N), .CntDw(W)) bus ();

  esc_phase_timer #(.N_ESC_SEV(N), .CntDw(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  int pc[4];
  int mp[4];
  int tmo;
  logic [3:0] sen;

  typedef struct {
    logic       clr;
    logic       trig;
    logic       en;
    logic       ten;
    logic [2:0] st;
    int         cnt;
    logic [3:0] eo;
  } vec_t;

  vec_t tv[13];

  function automatic vec_t mk(logic clr, logic trig, logic en, logic ten,
                              logic [2:0] st, int cnt, logic [3:0] eo);
    vec_t v;
    v.clr = clr; v.trig = trig; v.en = en; v.ten = ten;
    v.st = st; v.cnt = cnt; v.eo = eo;
    return v;
  endfunction

  task automatic set_cfg();
    for (int i = 0; i < 4; i++) begin
      bus.phase_cyc_i[i*W +: W] = W'(pc[i]);
      bus.esc_map_i[2*i +: 2]   = 2'(mp[i]);
    end
    bus.timeout_cyc_i = W'(tmo);
    bus.esc_sig_en_i  = sen;
  endtask

  task automatic set_in(input logic clr, input logic trig, input logic en, input logic ten);
    bus.clr_i        = clr;
    bus.accum_trig_i = trig;
    bus.en_i         = en;
    bus.timeout_en_i = ten;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [2:0] st, input int cnt, input logic [3:0] eo);
    checks++;
    if (bus.esc_state_o !== st || bus.esc_cnt_o !== W'(cnt) || bus.esc_en_o !== eo) begin
      errors++;
      $display("FAIL %s: got state=%b cnt=%0d en=%b, expected state=%b cnt=%0d en=%b",
               name, bus.esc_state_o, bus.esc_cnt_o, bus.esc_en_o, st, cnt, eo);
    end
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Reference model: elapsed time since a sequence/timeout began, mapped onto phases by prefix sums.
  int m_mode;  // 0 idle, 1 timeout, 2 in phases, 3 terminal
  int m_t;
  int m_e;

  function automatic int dur(int i);
    return (pc[i] == 0) ? 1 : pc[i];
  endfunction

  function automatic int total_dur();
    return dur(0) + dur(1) + dur(2) + dur(3);
  endfunction

  task automatic model_step(input logic clr, input logic trig, input logic en, input logic ten);
    bit lock;
`ifdef ESC_PHASE_TIMER_CLR_LOCK_EN
    lock = 1'b1;
`else
    lock = 1'b0;
`endif
    if (clr && !(lock && m_mode == 2)) begin
      m_mode = 0; m_t = 0; m_e = 0;
    end else begin
      case (m_mode)
        0: if (en && trig) begin m_mode = 2; m_e = 0; end
           else if (en && ten && tmo != 0) begin m_mode = 1; m_t = 0; end
        1: if (trig) begin m_mode = 2; m_e = 0; end
           else if (!ten) begin m_mode = 0; m_t = 0; end
           else if (m_t + 1 >= tmo) begin m_mode = 2; m_e = 0; end
           else m_t++;
        2: if (m_e + 1 >= total_dur()) m_mode = 3;
           else m_e++;
        default: ;
      endcase
    end
  endtask

  task automatic model_exp(output logic [2:0] st, output int cnt, output logic [3:0] eo);
    int idx, base;
    st = 3'b000; cnt = 0; eo = 4'b0000;
    case (m_mode)
      1: begin st = 3'b001; cnt = m_t; end
      2: begin
        idx = 0; base = 0;
        while (idx < 3 && m_e >= base + dur(idx)) begin
          base += dur(idx);
          idx++;
        end
        st  = 3'(4 + idx);
        cnt = m_e - base;
        for (int k = 0; k < N; k++) eo[k] = sen[k] && (idx >= mp[k]);
      end
      3: st = 3'b011;
      default: ;
    endcase
  endtask

  initial begin
    logic [2:0] est;
    int         ecnt;
    logic [3:0] eeo;
    int         guard;

    pc = '{1, 2, 3, 4};
    mp = '{0, 1, 2, 3};
    tmo = 5;
    sen = 4'hF;
    set_cfg();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);

    #12;
    chk("reset_held", 3'b000, 0, 4'b0000);
    rst_n = 1'b1;
    step();
    chk("reset_released", 3'b000, 0, 4'b0000);

    // Full trigger sequence: 1/2/3/4 cycles with signals joining one per phase.
    tv[0] = mk(0, 1, 1, 0, 3'b100, 0, 4'b0001);
    tv[1] = mk(0, 0, 1, 0, 3'b101, 0, 4'b0011);
    tv[2] = mk(0, 0, 1, 0, 3'b101, 1, 4'b0011);
    tv[3] = mk(0, 0, 1, 0, 3'b110, 0, 4'b0111);
    tv[4] = mk(0, 1, 1, 1, 3'b110, 1, 4'b0111);
    tv[5] = mk(0, 0, 0, 0, 3'b110, 2, 4'b0111);
    tv[6] = mk(0, 0, 1, 0, 3'b111, 0, 4'b1111);
    tv[7] = mk(0, 0, 1, 0, 3'b111, 1, 4'b1111);
    tv[8] = mk(0, 0, 1, 0, 3'b111, 2, 4'b1111);
    tv[9] = mk(0, 0, 1, 0, 3'b111, 3, 4'b1111);
    tv[10] = mk(0, 0, 1, 0, 3'b011, 0, 4'b0000);
    tv[11] = mk(0, 1, 1, 1, 3'b011, 0, 4'b0000);
    tv[12] = mk(1, 0, 0, 0, 3'b000, 0, 4'b0000);
    for (int i = 0; i < 13; i++) begin
      set_in(tv[i].clr, tv[i].trig, tv[i].en, tv[i].ten);
      step();
      chk($sformatf("vec%0d", i), tv[i].st, tv[i].cnt, tv[i].eo);
    end

    // Timeout expiry: five cycles in Timeout, then Phase0.
    set_in(0, 0, 1, 1);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("tmo_cnt%0d", c), 3'b001, c, 4'b0000);
    end
    step();
    chk("tmo_expire", 3'b100, 0, 4'b0001);
    set_in(1, 0, 0, 0);
    step();
    chk("tmo_clr", 3'b000, 0, 4'b0000);

    // Timeout dropped at cnt 2.
    set_in(0, 0, 1, 1);
    step(); step(); step();
    chk("drop_cnt2", 3'b001, 2, 4'b0000);
    set_in(0, 0, 1, 0);
    step();
    chk("drop_idle", 3'b000, 0, 4'b0000);

    // Trigger during Timeout at cnt 3.
    set_in(0, 0, 1, 1);
    step(); step(); step(); step();
    chk("trig_tmo_cnt3", 3'b001, 3, 4'b0000);
    set_in(0, 1, 0, 1);
    step();
    chk("trig_tmo_p0", 3'b100, 0, 4'b0001);
    set_in(1, 0, 0, 0);
    step();

    // Zero-length phases: one cycle each.
    pc = '{0, 0, 0, 0};
    set_cfg();
    set_in(0, 1, 1, 0);
    step();
    chk("zero_p0", 3'b100, 0, 4'b0001);
    set_in(0, 0, 0, 0);
    step(); chk("zero_p1", 3'b101, 0, 4'b0011);
    step(); chk("zero_p2", 3'b110, 0, 4'b0111);
    step(); chk("zero_p3", 3'b111, 0, 4'b1111);
    step(); chk("zero_term", 3'b011, 0, 4'b0000);

    // Clear while in Phase1.
    pc = '{1, 2, 3, 4};
    set_cfg();
    set_in(1, 0, 0, 0);
    step();
    set_in(0, 1, 1, 0);
    step();
    set_in(0, 0, 0, 0);
    step();
    chk("clr_pre_p1", 3'b101, 0, 4'b0011);
    set_in(1, 0, 0, 0);
    step();
`ifdef ESC_PHASE_TIMER_CLR_LOCK_EN
    chk("clr_p1_locked", 3'b101, 1, 4'b0011);
    set_in(0, 0, 0, 0);
`else
    chk("clr_p1_idle", 3'b000, 0, 4'b0000);
    set_in(0, 1, 1, 0);
    step();
    set_in(0, 0, 0, 0);
`endif
    guard = 0;
    while (bus.esc_state_o !== 3'b011 && guard < 30) begin
      step();
      guard++;
    end
    checks++;
    if (bus.esc_state_o !== 3'b011) begin
      errors++;
      $display("FAIL reach_terminal: got state=%b after %0d cycles, expected 011", bus.esc_state_o, guard);
    end
    set_in(1, 0, 0, 0);
    step();
    chk("clr_terminal", 3'b000, 0, 4'b0000);

    // Asynchronous reset in Phase2, between clock edges.
    pc = '{1, 1, 3, 1};
    set_cfg();
    set_in(0, 1, 1, 0);
    step();
    set_in(0, 0, 0, 0);
    step(); step();
    chk("pre_rst_p2", 3'b110, 0, 4'b0111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 3'b000, 0, 4'b0000);
    #1;
    rst_n = 1'b1;
    step();

    // Randomized episodes against the reference model; config fixed per episode.
    for (int ep = 0; ep < 40; ep++) begin
      logic ten_s;
      hard_reset();
      for (int i = 0; i < 4; i++) begin
        pc[i] = $urandom_range(0, 4);
        mp[i] = $urandom_range(0, 3);
      end
      tmo = $urandom_range(0, 8);
      sen = 4'($urandom_range(0, 15));
      set_cfg();
      m_mode = 0; m_t = 0; m_e = 0;
      ten_s = 1'($urandom_range(0, 1));
      for (int c = 0; c < 60; c++) begin
        logic r_clr, r_trig, r_en;
        if ($urandom_range(0, 9) == 0) ten_s = ~ten_s;
        r_clr  = ($urandom_range(0, 39) == 0);
        r_trig = ($urandom_range(0, 15) == 0);
        r_en   = ($urandom_range(0, 7) != 0);
        set_in(r_clr, r_trig, r_en, ten_s);
        step();
        model_step(r_clr, r_trig, r_en, ten_s);
        model_exp(est, ecnt, eeo);
        chk($sformatf("rand_ep%0d_c%0d", ep, c), est, ecnt, eeo);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
